// File: rtl/mult_accum.sv
// Dot-product multiply-accumulate around an external combinational 4x4 multiplier.
// Ports: in_* operand stream (valid/ready, in_last closes a product), mul_* external
//   multiplier hookup, out_* result (valid/ready) with sum, term count and overflow flag.
// Latency: result valid 2 cycles after the closing transfer; input stalls while a result is pending.
module mult_accum #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic [3:0]       mul_x,
  output logic [3:0]       mul_y,
  input  logic [7:0]       mul_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               s1_valid_q, s1_last_q;
  logic [3:0]         mul_x_q, mul_y_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   out_acc_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;

  logic               xfer;
  logic               close_term;
  logic               cnt_max;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_upd;
  logic [CNT_W-1:0]   cnt_upd;
  logic               ovf_upd;

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        // Held low during reset so nothing is accepted while rst_n is asserted.
        in_ready = rst_n;
        if (in_valid && rst_n && in_last) state_d = FLUSH;
      end
      FLUSH: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign xfer = in_valid & in_ready;

  // Stage-1 accumulate: mul_o is the product of the registered operands.
  assign sum     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_o};
  assign cnt_max = &cnt_q;
  assign acc_upd = s1_valid_q ? sum[ACC_W-1:0] : acc_q;
  assign cnt_upd = (s1_valid_q && !cnt_max) ? cnt_q + 1'b1 : cnt_q;
  assign ovf_upd = s1_valid_q ? (ovf_q | sum[ACC_W] | cnt_max) : ovf_q;

  // The closing term sits in stage 1 exactly during FLUSH; its updated totals
  // are captured as the result and the accumulator restarts from zero.
  assign close_term = s1_valid_q & s1_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= xfer;
      if (xfer) begin
        mul_x_q   <= in_x;
        mul_y_q   <= in_y;
        s1_last_q <= in_last;
      end
      if (close_term) begin
        out_acc_q   <= acc_upd;
        out_count_q <= cnt_upd;
        out_ovf_q   <= ovf_upd;
        acc_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= 1'b0;
      end else begin
        acc_q <= acc_upd;
        cnt_q <= cnt_upd;
        ovf_q <= ovf_upd;
      end
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and result width in bits; legal range 8..32.
REQ-002 SHALL have parameter CNT_W, default 4: term-counter width in bits; legal range 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-007 SHALL have port in_x, input, 4 bits: multiplicand, unsigned.
REQ-008 SHALL have port in_y, input, 4 bits: multiplier, unsigned.
REQ-009 SHALL have port in_last, input, 1 bit: this pair is the final term of the current dot product.
REQ-010 SHALL have port mul_x, output, 4 bits: registered operand driven to the 4x4 multiplier x input.
REQ-011 SHALL have port mul_y, output, 4 bits: registered operand driven to the 4x4 multiplier y input.
REQ-012 SHALL have port mul_o, input, 8 bits: combinational product returned by the multiplier, equal to mul_x*mul_y in the same cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: result available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port out_acc, output, ACC_W bits: dot-product sum, modulo 2^ACC_W.
REQ-016 SHALL have port out_count, output, CNT_W bits: number of terms in the dot product, saturating.
REQ-017 SHALL have port out_ovf, output, 1 bit: sum wrapped or count saturated.

Function
REQ-018 SHALL define a transfer as in_valid&in_ready at a rising edge, and a result handoff as out_valid&out_ready at a rising edge.
REQ-019 SHALL implement FSM states ACCUM, FLUSH and OUT; in_ready=1 only in ACCUM, and out_valid=1 only in OUT.
REQ-020 SHALL, on a transfer, load mul_x<=in_x, mul_y<=in_y, s1_valid<=1 and s1_last<=in_last; with no transfer, s1_valid<=0 and mul_x/mul_y hold their values.
REQ-021 SHALL, when s1_valid=1, compute sum=acc+zero-extended mul_o, with acc<=sum[ACC_W-1:0]; cnt<=cnt+1 saturating at 2^CNT_W-1; ovf<=ovf|carry-out|(cnt at max).
REQ-022 SHALL, on a transfer with in_last=0, stay in ACCUM; throughput is one term per cycle.
REQ-023 SHALL, on a transfer with in_last=1, go from ACCUM to FLUSH.
REQ-024 SHALL, in FLUSH, load out_acc, out_count and out_ovf from the updated values of REQ-021, clear acc, cnt and ovf to 0, and go to OUT.
REQ-025 SHALL give a latency of 2 cycles from the last transfer edge to out_valid=1.
REQ-026 SHALL hold out_acc, out_count and out_ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, in OUT with out_ready=1, go to ACCUM on that edge; in_ready=1 in the following cycle.
REQ-028 SHALL ignore in_x, in_y and in_last whenever in_ready=0.
REQ-029 SHALL treat in_last=1 on the first term as a valid 1-term dot product.
REQ-030 SHALL ignore out_ready outside OUT.

Reset
REQ-031 SHALL, on rst_n=0 at a rising edge, set: state=ACCUM, s1_valid=0, s1_last=0, mul_x=0, mul_y=0, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
REQ-032 SHALL give rst_n priority over all other inputs; an in-flight term or pending result is discarded, and no partial result is emitted afterwards.
REQ-033 SHALL drive in_ready=0 while rst_n=0, and in_ready=1 in the first cycle after release.

Verification
REQ-034 SHALL cover: pairs (3,5),(15,15),(2,7,last) back-to-back, out_ready=1 -> out_valid 2 cycles after the last transfer with out_acc=254, out_count=3, out_ovf=0.
REQ-035 SHALL cover: single pair (0,9,last) -> out_acc=0, out_count=1, out_ovf=0.
REQ-036 SHALL cover: ACC_W=8, pairs (15,15),(15,15,last) -> out_acc=194, out_ovf=1.
REQ-037 SHALL cover: CNT_W=2, 5 pairs (1,1) with last on the 5th -> out_acc=5, out_count=3, out_ovf=1.
REQ-038 SHALL cover: result pending with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no transfer; out_ready=1 -> in_ready=1 next cycle and the next dot product starts from acc=0.
REQ-039 SHALL cover: rst_n=0 one cycle after the 2nd of 3 terms -> no out_valid; a new (2,3,last) then gives out_acc=6, out_count=1.
